// File: rtl/generador_trama_if.sv
// Frame generator request/stream bundle.
// Requester drives the frame; the generator drives the stream.
interface generador_trama_if #(
  parameter int SAMPLES   = 128,
  parameter int DATA_BITS = 32
);
  logic                 Start;
  logic [SAMPLES-1:0]   Preamble;
  logic [DATA_BITS-1:0] Payload;
  logic                 Ready;
  logic                 TxBit;
  logic                 TxValid;
  logic                 SymStrobe;
  logic                 Done;

  modport master (
    output Start,
    output Preamble,
    output Payload,
    input  Ready,
    input  TxBit,
    input  TxValid,
    input  SymStrobe,
    input  Done
  );

  modport slave (
    input  Start,
    input  Preamble,
    input  Payload,
    output Ready,
    output TxBit,
    output TxValid,
    output SymStrobe,
    output Done
  );
endinterface

// File: rtl/generador_trama.sv
// Oversampled frame generator: preamble, payload, idle guard.
// Each symbol is held OSF enabled cycles, MSB first.
module generador_trama #(
  parameter int SAMPLES   = 128,
  parameter int OSF       = 8,
  parameter int DATA_BITS = 32,
  parameter int GUARD     = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Enable,
  generador_trama_if.slave bus
);

  localparam int MAX_A =
    (SAMPLES > DATA_BITS) ? SAMPLES : DATA_BITS;
  localparam int MAX_S =
    (MAX_A > GUARD) ? MAX_A : GUARD;
  localparam int CW = $clog2(MAX_S + 1);
  localparam int SW = (OSF > 1) ? $clog2(OSF) : 1;

  localparam logic [CW-1:0] PRE_LAST =
    CW'(SAMPLES - 1);
  localparam logic [CW-1:0] PAY_LAST =
    CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] GRD_LAST =
    CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [SW-1:0] SMP_LAST =
    SW'(OSF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
    S_GRD
  } state_t;

  state_t               state;
  logic [SW-1:0]        smp;
  logic [CW-1:0]        sym;
  logic [SAMPLES-1:0]   pre_sr;
  logic [DATA_BITS-1:0] pay_sr;

  logic ready_q;
  logic bit_q;
  logic valid_q;
  logic stb_q;
  logic done_q;

  assign bus.Ready     = ready_q;
  assign bus.TxBit     = bit_q;
  assign bus.TxValid   = valid_q;
  assign bus.SymStrobe = stb_q;
  assign bus.Done      = done_q;

  // Frame FSM with counters, shifters and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= S_IDLE;
      smp     <= '0;
      sym     <= '0;
      pre_sr  <= '0;
      pay_sr  <= '0;
      ready_q <= 1'b1;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!Enable) begin
        stb_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
            if (bus.Start && ready_q) begin
              state   <= S_PRE;
              smp     <= '0;
              sym     <= '0;
              pre_sr  <= bus.Preamble << 1;
              pay_sr  <= bus.Payload;
              bit_q   <= bus.Preamble[SAMPLES-1];
              valid_q <= 1'b1;
              stb_q   <= 1'b1;
              ready_q <= 1'b0;
            end
          end

          S_PRE: begin
            if (smp == SMP_LAST) begin
              smp   <= '0;
              stb_q <= 1'b1;
              if (sym == PRE_LAST) begin
                state  <= S_PAY;
                sym    <= '0;
                bit_q  <= pay_sr[DATA_BITS-1];
                pay_sr <= pay_sr << 1;
              end else begin
                sym    <= sym + 1'b1;
                bit_q  <= pre_sr[SAMPLES-1];
                pre_sr <= pre_sr << 1;
              end
            end else begin
              smp   <= smp + 1'b1;
              stb_q <= 1'b0;
            end
          end

          S_PAY: begin
            if (smp == SMP_LAST) begin
              smp <= '0;
              if (sym == PAY_LAST) begin
                sym     <= '0;
                bit_q   <= 1'b0;
                valid_q <= 1'b0;
                stb_q   <= 1'b0;
                if (GUARD > 0) begin
                  state <= S_GRD;
                end else begin
                  state   <= S_IDLE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                end
              end else begin
                sym    <= sym + 1'b1;
                bit_q  <= pay_sr[DATA_BITS-1];
                pay_sr <= pay_sr << 1;
                stb_q  <= 1'b1;
              end
            end else begin
              smp   <= smp + 1'b1;
              stb_q <= 1'b0;
            end
          end

          S_GRD: begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
            if (smp == SMP_LAST) begin
              smp <= '0;
              if (sym == GRD_LAST) begin
                state   <= S_IDLE;
                sym     <= '0;
                done_q  <= 1'b1;
                ready_q <= 1'b1;
              end else begin
                sym <= sym + 1'b1;
              end
            end else begin
              smp <= smp + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_generador_trama.sv
// Directed bench for generador_trama (SAMPLES=4, OSF=2, DATA_BITS=4).
// u0 has GUARD=1, u1 has GUARD=0; both see the same stimulus.
module tb_generador_trama;

  logic Clk;
  logic Reset;
  logic Enable;

  int errors = 0;
  int checks = 0;

  generador_trama_if #(.SAMPLES(4), .DATA_BITS(4)) bif0 ();
  generador_trama_if #(.SAMPLES(4), .DATA_BITS(4)) bif1 ();

  generador_trama #(
    .SAMPLES(4), .OSF(2), .DATA_BITS(4), .GUARD(1)
  ) u0 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .bus(bif0)
  );

  generador_trama #(
    .SAMPLES(4), .OSF(2), .DATA_BITS(4), .GUARD(0)
  ) u1 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .bus(bif1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] p,
                       input logic [3:0] d);
    bif0.Start = s;  bif1.Start = s;
    bif0.Preamble = p; bif1.Preamble = p;
    bif0.Payload = d;  bif1.Payload = d;
  endtask

  logic [1:16] seq;
  logic [3:0]  pre;
  int          m;
  logic        seen;

  initial begin
    seq = 16'b1100_1111_0011_1100;
    pre = 4'b1011;
    Reset = 1'b0;
    Enable = 1'b1;
    drive(1'b0, pre, 4'b0110);
    tick;
    tick;
    Reset = 1'b1;

    chk("rst_ready", bif0.Ready, 1'b1);
    chk("rst_bit", bif0.TxBit, 1'b0);
    chk("rst_valid", bif0.TxValid, 1'b0);
    chk("rst_stb", bif0.SymStrobe, 1'b0);
    chk("rst_done", bif0.Done, 1'b0);

    // Basic frame; Start pulse and preamble change mid-frame.
    drive(1'b1, pre, 4'b0110);
    tick;
    drive(1'b0, pre, 4'b0110);
    for (int k = 1; k <= 19; k++) begin
      if (k <= 16) begin
        chk("t1_bit", bif0.TxBit, seq[k]);
        chk("t1_valid", bif0.TxValid, 1'b1);
        chk("g0_bit", bif1.TxBit, seq[k]);
      end else begin
        chk("t1_valid0", bif0.TxValid, 1'b0);
        chk("t1_bit0", bif0.TxBit, 1'b0);
      end
      chk("t1_stb", bif0.SymStrobe,
          (k % 2 == 1) && (k <= 15));
      chk("t1_done", bif0.Done, k == 19);
      chk("t1_ready", bif0.Ready, k == 19);
      chk("g0_stb", bif1.SymStrobe,
          (k % 2 == 1) && (k <= 15));
      chk("g0_done", bif1.Done, k == 17);
      if (k == 3) drive(1'b1, 4'b0100, 4'b0110);
      else drive(1'b0, (k > 3) ? 4'b0100 : pre, 4'b0110);
      tick;
    end
    chk("t1_done_clr", bif0.Done, 1'b0);
    chk("t1_idle_valid", bif0.TxValid, 1'b0);

    // Enable low for cycles N+5..N+7, and in the Done cycle.
    drive(1'b0, pre, 4'b0110);
    tick;
    drive(1'b1, pre, 4'b0110);
    tick;
    drive(1'b0, pre, 4'b0110);
    for (int k = 1; k <= 23; k++) begin
      m = (k <= 5) ? k : ((k <= 8) ? 5 : k - 3);
      if (m <= 16) chk("t2_bit", bif0.TxBit, seq[m]);
      chk("t2_valid", bif0.TxValid, m <= 16);
      chk("t2_stb", bif0.SymStrobe,
          !(k >= 6 && k <= 8) && (m % 2 == 1) && (m <= 15));
      chk("t2_done", bif0.Done, m == 19);
      Enable = !((k >= 5 && k <= 7) || k == 22);
      tick;
    end
    Enable = 1'b1;

    // Start held high: back-to-back frames.
    drive(1'b1, pre, 4'b0110);
    tick;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 16) chk("t3_bit", bif0.TxBit, seq[k]);
      if (k == 19) begin
        chk("t3_done", bif0.Done, 1'b1);
        chk("t3_ready", bif0.Ready, 1'b1);
      end
      if (k == 20) begin
        chk("t3_f2_valid", bif0.TxValid, 1'b1);
        chk("t3_f2_stb", bif0.SymStrobe, 1'b1);
        chk("t3_f2_bit", bif0.TxBit, 1'b0);
        chk("t3_f2_ready", bif0.Ready, 1'b0);
      end
      if (k == 3) drive(1'b1, 4'b0100, 4'b0110);
      if (k < 20) tick;
    end
    drive(1'b0, pre, 4'b0110);

    // Reset mid-frame, with Start high and Enable low.
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
    tick;
    chk("t4_ready", bif0.Ready, 1'b1);
    drive(1'b1, pre, 4'b0110);
    tick;
    drive(1'b0, pre, 4'b0110);
    for (int k = 1; k <= 9; k++) tick;
    chk("t4_mid_valid", bif0.TxValid, 1'b1);
    Reset = 1'b0;
    Enable = 1'b0;
    drive(1'b1, pre, 4'b0110);
    tick;
    Reset = 1'b1;
    Enable = 1'b1;
    drive(1'b0, pre, 4'b0110);
    chk("t4_rst_ready", bif0.Ready, 1'b1);
    chk("t4_rst_bit", bif0.TxBit, 1'b0);
    chk("t4_rst_valid", bif0.TxValid, 1'b0);
    chk("t4_rst_stb", bif0.SymStrobe, 1'b0);
    chk("t4_rst_done", bif0.Done, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      seen = seen | bif0.Done | bif0.TxValid;
      tick;
    end
    chk("t4_quiet", seen, 1'b0);

    // Start ignored while Enable is low.
    Enable = 1'b0;
    drive(1'b1, pre, 4'b0110);
    tick;
    Enable = 1'b1;
    drive(1'b0, pre, 4'b0110);
    tick;
    chk("t5_ready", bif0.Ready, 1'b1);
    chk("t5_valid", bif0.TxValid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
